ahb_bus_arbiter: RTL and testbench



---
 rtl/ahb_pkg.sv | 46 ++++
 rtl/ahb_bus_arbiter_if.sv | 33 +++
 rtl/ahb_bus_arbiter_rr_priority_picker.sv | 39 +++
 rtl/ahb_bus_arbiter.sv | 100 ++++++++++
 tb/tb_ahb_bus_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite/AHB2 encodings and helpers for the bus arbiter slice.
//   htrans_e            : HTRANS transfer-type codes
//   hburst_e            : HBURST burst-type codes
//   burst_beats_minus1  : remaining beats after the NONSEQ beat of a burst
//   is_fixed_burst      : burst has a defined length (WRAPx / INCRx)
// ----------------------------------------------------------------------------
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   // SINGLE and undefined-length INCR carry no beat count.
   function automatic logic [3:0] burst_beats_minus1(input logic [2:0] hburst);
      logic [3:0] v_n;
      v_n = 4'd0;
      case (hburst_e'(hburst))
         HBURST_WRAP4,  HBURST_INCR4:  v_n = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  v_n = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: v_n = 4'd15;
         default:                      v_n = 4'd0;
      endcase
      return v_n;
   endfunction

   function automatic logic is_fixed_burst(input logic [2:0] hburst);
      return (burst_beats_minus1(hburst) != 4'd0);
   endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// ahb_bus_arbiter_if
// Arbitration-side AHB signals shared between the requesting masters / muxed
// bus (modport master) and the arbiter (modport slave).
//   HBUSREQ, HLOCK      : per-master request / lock request
//   HTRANS, HBURST      : muxed transfer and burst type of address-phase owner
//   HREADY              : muxed slave ready
//   HGRANT              : one-hot grant
//   HMASTER, HMASTLOCK  : address-phase owner index and lock flag
// ----------------------------------------------------------------------------
interface ahb_bus_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned MID_W       = 2
);
   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic [1:0]             HTRANS;
   logic [2:0]             HBURST;
   logic                   HREADY;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [MID_W-1:0]       HMASTER;
   logic                   HMASTLOCK;

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      input  HGRANT, HMASTER, HMASTLOCK
   );

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      output HGRANT, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_bus_arbiter_rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker: scans i_req starting one past i_ptr and
// wrapping, so the pointer position itself is checked last.
//   i_req    : request vector
//   i_ptr    : index of the most recent winner
//   o_winner : index of the first requester found
//   o_valid  : at least one request present
// ----------------------------------------------------------------------------
module rr_priority_picker #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [W-1:0] o_winner,
   output logic         o_valid
);

   always_comb begin
      int unsigned v_idx;
      logic [W-1:0] v_sel;
      logic v_found;
      v_idx    = 0;
      v_sel    = '0;
      v_found  = 1'b0;
      o_winner = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         v_idx = (32'(i_ptr) + k) % N;
         v_sel = W'(v_idx);
         if (!v_found && i_req[v_sel]) begin
            v_found  = 1'b1;
            o_winner = v_sel;
         end
      end
      o_valid = v_found;
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_bus_arbiter
// Round-robin AHB bus arbiter with a park (default) master; burst- and
// lock-aware. The grant runs one cycle ahead of address-phase ownership.
//   HCLK     : bus clock
//   HRESETn  : synchronous active-low reset
//   bus      : arbitration signals (slave modport of ahb_bus_arbiter_if)
// ----------------------------------------------------------------------------
module ahb_bus_arbiter #(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter int unsigned DEFAULT_MASTER = 0,
   parameter int unsigned MID_W          = 2
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   ahb_bus_arbiter_if.slave  bus
);
   import ahb_pkg::*;

   localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [MID_W-1:0]       DEF_IDX    = MID_W'(DEFAULT_MASTER);

   logic [NUM_MASTERS-1:0] r_grant;
   logic [MID_W-1:0]       r_master;
   logic                   r_mastlock;
   logic [3:0]             r_cnt;
   logic [MID_W-1:0]       r_ptr;
   logic                   r_lock_hold;

   logic [MID_W-1:0]       w_grant_idx;
   logic [MID_W-1:0]       w_winner;
   logic                   w_win_valid;
   logic                   w_arb_ok;
   logic [3:0]             w_cnt_next;
   logic                   w_fixed_nonseq;

   rr_priority_picker #(
      .N (NUM_MASTERS),
      .W (MID_W)
   ) u_picker (
      .i_req    (bus.HBUSREQ),
      .i_ptr    (r_ptr),
      .o_winner (w_winner),
      .o_valid  (w_win_valid)
   );

   always_comb begin
      w_grant_idx = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (r_grant[i]) w_grant_idx = MID_W'(i);
      end
   end

   assign w_fixed_nonseq = (htrans_e'(bus.HTRANS) == HTRANS_NONSEQ) && is_fixed_burst(bus.HBURST);

   // Count 1 with SEQ is the last beat's address phase: handing over here lets
   // the new owner's address follow back-to-back.
   assign w_arb_ok = !r_lock_hold &&
                     (((r_cnt == 4'd0) && !w_fixed_nonseq) ||
                      ((r_cnt == 4'd1) && (htrans_e'(bus.HTRANS) == HTRANS_SEQ)));

   always_comb begin
      w_cnt_next = r_cnt;
      unique case (htrans_e'(bus.HTRANS))
         HTRANS_IDLE:   w_cnt_next = 4'd0;
         HTRANS_BUSY:   w_cnt_next = r_cnt;
         HTRANS_NONSEQ: w_cnt_next = burst_beats_minus1(bus.HBURST);
         HTRANS_SEQ:    w_cnt_next = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_grant     <= DEF_ONEHOT;
         r_master    <= DEF_IDX;
         r_mastlock  <= 1'b0;
         r_cnt       <= 4'd0;
         r_ptr       <= DEF_IDX;
         r_lock_hold <= 1'b0;
      end else if (bus.HREADY) begin
         r_master    <= w_grant_idx;
         r_mastlock  <= bus.HLOCK[w_grant_idx];
         r_lock_hold <= bus.HLOCK[w_grant_idx];
         r_cnt       <= w_cnt_next;
         if (w_arb_ok) begin
            if (w_win_valid) begin
               r_grant <= NUM_MASTERS'(1) << w_winner;
               r_ptr   <= w_winner;
            end else begin
               r_grant <= DEF_ONEHOT;
            end
         end
      end
   end

   assign bus.HGRANT    = r_grant;
   assign bus.HMASTER   = r_master;
   assign bus.HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_bus_arbiter
// Scoreboard bench: each stimulus cycle pushes the reference model's expected
// post-edge outputs; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_ahb_bus_arbiter;

   localparam int N   = 4;
   localparam int DEF = 0;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   ahb_bus_arbiter_if #(.NUM_MASTERS(N), .MID_W(2)) bus ();

   ahb_bus_arbiter #(
      .NUM_MASTERS    (N),
      .DEFAULT_MASTER (DEF),
      .MID_W          (2)
   ) dut (
      .HCLK    (clk),
      .HRESETn (rstn),
      .bus     (bus)
   );

   typedef struct {
      logic [3:0] grant;
      logic [1:0] master;
      logic       mlock;
   } exp_t;

   exp_t sb[$];
   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (owner indices as plain integers)
   int m_grant, m_master, m_ptr, m_left;
   bit m_mlock, m_hold;
   int beats_of[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

   task automatic model_edge();
      int g, w, c, nb;
      bit ok, found;
      exp_t e;
      if (!rstn) begin
         m_grant = DEF; m_master = DEF; m_mlock = 0;
         m_left = 0; m_ptr = DEF; m_hold = 0;
      end else if (bus.HREADY) begin
         g  = m_grant;
         nb = beats_of[bus.HBURST];
         ok = !m_hold &&
              ((m_left == 0 && !(bus.HTRANS == 2'd2 && nb > 1)) ||
               (m_left == 1 && bus.HTRANS == 2'd3));
         case (bus.HTRANS)
            2'd0: m_left = 0;
            2'd1: ;
            2'd2: m_left = nb - 1;
            2'd3: if (m_left > 0) m_left = m_left - 1;
         endcase
         m_master = g;
         m_mlock  = bus.HLOCK[g];
         m_hold   = bus.HLOCK[g];
         if (ok) begin
            found = 0; w = 0;
            for (int k = 1; k <= N; k++) begin
               c = (m_ptr + k) % N;
               if (!found && bus.HBUSREQ[c]) begin found = 1; w = c; end
            end
            if (found) begin m_grant = w; m_ptr = w; end
            else m_grant = DEF;
         end
      end
      e.grant  = 4'(1 << m_grant);
      e.master = 2'(m_master);
      e.mlock  = m_mlock;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [3:0] req, input logic [3:0] lck,
                        input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
      bus.HBUSREQ = req;
      bus.HLOCK   = lck;
      bus.HTRANS  = tr;
      bus.HBURST  = bu;
      bus.HREADY  = rdy;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (bus.HGRANT !== e.grant) begin
               n_fail++;
               $display("FAIL grant: got %b want %b at %0t", bus.HGRANT, e.grant, $time);
            end
            n_tests++;
            if (bus.HMASTER !== e.master) begin
               n_fail++;
               $display("FAIL hmaster: got %0d want %0d at %0t", bus.HMASTER, e.master, $time);
            end
            n_tests++;
            if (bus.HMASTLOCK !== e.mlock) begin
               n_fail++;
               $display("FAIL hmastlock: got %b want %b at %0t", bus.HMASTLOCK, e.mlock, $time);
            end
            n_tests++;
            if (!$onehot(bus.HGRANT)) begin
               n_fail++;
               $display("FAIL onehot: got %b want one-hot at %0t", bus.HGRANT, $time);
            end
         end
      end
   end

   // Stimulus
   initial begin
      rstn = 1'b0;
      drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1);
      repeat (3) step();
      rstn = 1'b1;
      repeat (10) step();

      // Alternating SINGLE requests from masters 1 and 2
      drive(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1);
      repeat (12) step();

      // INCR4 bursts with competing request
      repeat (3) begin
         drive(4'b0110, 4'b0000, 2'd2, 3'd3, 1'b1); step();
         repeat (3) begin drive(4'b0110, 4'b0000, 2'd3, 3'd3, 1'b1); step(); end
      end

      // INCR8 with wait states at beat 5
      drive(4'b0110, 4'b0000, 2'd2, 3'd5, 1'b1); step();
      repeat (3) begin drive(4'b0110, 4'b0000, 2'd3, 3'd5, 1'b1); step(); end
      repeat (3) begin drive(4'b0110, 4'b0000, 2'd3, 3'd5, 1'b0); step(); end
      repeat (4) begin drive(4'b0110, 4'b0000, 2'd3, 3'd5, 1'b1); step(); end
      drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1); step();

      // Locked undefined-length INCR from master 3 against masters 1 and 2
      drive(4'b1000, 4'b1000, 2'd0, 3'd0, 1'b1); repeat (3) step();
      drive(4'b1110, 4'b1000, 2'd2, 3'd1, 1'b1); step();
      repeat (5) begin drive(4'b1110, 4'b1000, 2'd3, 3'd1, 1'b1); step(); end
      drive(4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1); repeat (4) step();

      // Reset in the middle of INCR16
      drive(4'b0110, 4'b0000, 2'd2, 3'd7, 1'b1); step();
      repeat (6) begin drive(4'b0110, 4'b0000, 2'd3, 3'd7, 1'b1); step(); end
      rstn = 1'b0;
      drive(4'b0110, 4'b0000, 2'd3, 3'd7, 1'b0); step();
      rstn = 1'b1;
      drive(4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1); repeat (6) step();

      // Randomised traffic
      repeat (800) begin
         rstn = ($urandom_range(0, 99) != 0);
         drive(4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
               2'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)),
               ($urandom_range(0, 3) != 0));
         step();
      end

      // Drain the scoreboard within a bounded number of cycles
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
